// File: rtl/temporal_pkg.sv
// Shared types and constants for the pulse-coded temporal (gamma-cycle) datapath.
package temporal_pkg;

    // Gamma-cycle framing used by benches and neighbouring temporal blocks.
    localparam int unsigned GAMMA_CYCLE_WIDTH = 16;
    localparam int unsigned PULSE_WIDTH       = 8;

    // Exclusive-min operator state: waiting, A owns q, B owns q, finished.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WIN_A = 2'd1,
        WIN_B = 2'd2,
        DONE  = 2'd3
    } xmin_state_t;

    // Output level for a given (next) state: only the current winner drives q.
    function automatic logic xmin_q(input xmin_state_t s, input logic a, input logic b);
        logic r;
        r = 1'b0;
        case (s)
            WIN_A:   r = a;
            WIN_B:   r = b;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector on a sampled pulse stream, re-armed at each gamma-cycle start.
module rise_detect (
    input  logic aclk,
    input  logic grst,
    input  logic d,
    output logic rise_c
);

    logic prev;

    // prev follows the input on every edge, grst included, so a level already
    // high across the gamma-cycle boundary is never seen as a new event.
    always_ff @(posedge aclk) begin
        prev <= d;
    end

    // No event can start on the gamma-cycle start edge itself.
    always_comb begin
        rise_c = d & ~prev & ~grst;
    end

endmodule

// File: rtl/exclusive_min_pw.sv
// Race-logic exclusive minimum: q reproduces the pulse of the strictly-first input.
module exclusive_min_pw
    import temporal_pkg::*;
(
    input  logic aclk,
    input  logic grst,
    input  logic a,
    input  logic b,
    output logic q
);

    xmin_state_t state;
    xmin_state_t next_state;
    logic        rise_a_c;
    logic        rise_b_c;
    logic        q_next;

    rise_detect u_rise_a (
        .aclk   (aclk),
        .grst   (grst),
        .d      (a),
        .rise_c (rise_a_c)
    );

    rise_detect u_rise_b (
        .aclk   (aclk),
        .grst   (grst),
        .d      (b),
        .rise_c (rise_b_c)
    );

    // State and output registers; grst starts a fresh gamma cycle with q low.
    always_ff @(posedge aclk) begin
        if (grst) begin
            state <= IDLE;
            q     <= 1'b0;
        end else begin
            state <= next_state;
            q     <= q_next;
        end
    end

    // Race resolution: first rise wins, a tie is "infinity", one pulse per cycle.
    always_comb begin
        next_state = state;
        q_next     = 1'b0;
        case (state)
            IDLE: begin
                if (rise_a_c && rise_b_c) begin
                    next_state = DONE;
                end else if (rise_a_c) begin
                    next_state = WIN_A;
                end else if (rise_b_c) begin
                    next_state = WIN_B;
                end
            end
            WIN_A: begin
                if (!a) begin
                    next_state = DONE;
                end
            end
            WIN_B: begin
                if (!b) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = DONE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        q_next = xmin_q(next_state, a, b);
    end

endmodule

// File: tb/tb_exclusive_min_pw.sv
// Directed bench for exclusive_min_pw: one table row per gamma cycle plus hand sequences.
module tb_exclusive_min_pw;
    import temporal_pkg::*;

    localparam int unsigned G = GAMMA_CYCLE_WIDTH;
    localparam int unsigned NVEC = 12;

    logic aclk;
    logic grst;
    logic a;
    logic b;
    logic q;

    int tests;
    int fails;

    typedef struct {
        string       name;
        logic [15:0] a_pat;
        logic [15:0] b_pat;
        logic [15:0] q_exp;
    } vec_t;

    vec_t vecs [NVEC];

    exclusive_min_pw dut (
        .aclk (aclk),
        .grst (grst),
        .a    (a),
        .b    (b),
        .q    (q)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one sampled cycle and return q as registered at that edge.
    task automatic do_cycle(input logic g, input logic av, input logic bv, output logic qv);
        @(negedge aclk);
        grst = g;
        a    = av;
        b    = bv;
        @(posedge aclk);
        #1 qv = q;
    endtask

    initial begin
        logic [15:0] trace;
        logic        qv;
        int          ones;

        tests = 0;
        fails = 0;
        grst  = 1'b0;
        a     = 1'b0;
        b     = 1'b0;

        // Bit t of each pattern is the level sampled t edges after the grst edge (t=0).
        vecs[0]  = '{"no_event",        16'h0000, 16'h0000, 16'h0000};
        vecs[1]  = '{"a_first",         16'h03FC, 16'h0FF0, 16'h03FC};
        vecs[2]  = '{"b_first",         16'h0FF0, 16'h03FC, 16'h03FC};
        vecs[3]  = '{"tie",             16'h00FC, 16'h00FC, 16'h0000};
        vecs[4]  = '{"second_rise",     16'h071C, 16'h0000, 16'h001C};
        vecs[5]  = '{"loser_falls_first",16'h03FC, 16'h0038, 16'h03FC};
        vecs[6]  = '{"a_at_t1",         16'h000E, 16'h0000, 16'h000E};
        vecs[7]  = '{"a_into_grst",     16'hFC00, 16'h0000, 16'hFC00};
        vecs[8]  = '{"a_held_b_wins",   16'h001F, 16'h003C, 16'h003C};
        vecs[9]  = '{"b_at_t15",        16'h0000, 16'h8000, 16'h8000};
        vecs[10] = '{"a_high_on_grst",  16'h000F, 16'h0000, 16'h0000};
        vecs[11] = '{"no_event_end",    16'h0000, 16'h0000, 16'h0000};

        // Reset state: first grst edge clears q.
        do_cycle(1'b1, 1'b0, 1'b0, qv);
        check("reset_q", 16'(qv), 16'h0000);

        // Table: back-to-back gamma cycles, levels carry across boundaries.
        for (int v = 0; v < int'(NVEC); v++) begin
            trace = '0;
            for (int t = 0; t < int'(G); t++) begin
                do_cycle(t == 0, vecs[v].a_pat[t], vecs[v].b_pat[t], qv);
                trace[t] = qv;
            end
            check({vecs[v].name, "_trace"}, trace, vecs[v].q_exp);
            check({vecs[v].name, "_q_at_grst"}, 16'(trace[0]), 16'h0000);
            if (v == 1 || v == 2) begin
                ones = $countones(trace);
                check({vecs[v].name, "_width"}, 16'(ones), 16'(PULSE_WIDTH));
            end
        end

        // Short gamma cycle: grst lands while A is winning, A stays high afterwards.
        do_cycle(1'b1, 1'b0, 1'b0, qv);
        do_cycle(1'b0, 1'b1, 1'b0, qv);
        check("short_win_rise", 16'(qv), 16'h0001);
        do_cycle(1'b0, 1'b1, 1'b0, qv);
        check("short_win_hold", 16'(qv), 16'h0001);
        do_cycle(1'b1, 1'b1, 1'b0, qv);
        check("grst_mid_pulse", 16'(qv), 16'h0000);
        for (int t = 1; t <= 3; t++) begin
            do_cycle(1'b0, 1'b1, 1'b0, qv);
            check($sformatf("held_no_redetect_t%0d", t), 16'(qv), 16'h0000);
        end
        do_cycle(1'b0, 1'b0, 1'b1, qv);
        check("b_wins_after_a_drop", 16'(qv), 16'h0001);
        do_cycle(1'b0, 1'b1, 1'b0, qv);
        check("b_drop_done", 16'(qv), 16'h0000);
        do_cycle(1'b0, 1'b0, 1'b1, qv);
        check("done_ignores_b", 16'(qv), 16'h0000);

        // Fresh cycle after that: a rise is a new, independent event.
        do_cycle(1'b1, 1'b0, 1'b0, qv);
        do_cycle(1'b0, 1'b1, 1'b0, qv);
        check("fresh_cycle_a_win", 16'(qv), 16'h0001);
        do_cycle(1'b0, 1'b0, 1'b0, qv);
        check("fresh_cycle_a_fall", 16'(qv), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
